// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//
// Run-control sequencer that sits behind the AXI-Lite register block. It turns
// the cpu_ctrl word and the PC-write strobe into the core's enable, soft reset
// and PC-load pins. It also produces the status word and the cycle and
// retired-instruction counters that software reads back.
//
// Optional feature: define CPU_WATCHDOG_EN to add a no-retire watchdog in RUN.
//
// Ports:
//   S_AXI_ACLK      in   clock
//   S_AXI_ARESETN   in   asynchronous active-low reset
//   cpu_ctrl        in   [0] run, [1] step, [2] soft reset, [3] break enable
//   axi_pc_write    in   PC value from the register interface
//   axi_pc_we       in   one-cycle PC write strobe
//   core_halt_req   in   core decoded EBREAK
//   core_retire     in   one-cycle pulse per retired instruction
//   core_en         out  pipeline advance enable (registered)
//   core_rst_n      out  core soft reset, active low (registered)
//   pc_load         out  one-cycle PC load pulse
//   pc_load_value   out  PC value to load
//   cpu_status      out  {instret[15:0], 7'b0, pc_rej, cause[1:0], wdt, halted, running, state}
//   cpu_running     out  state is RUN or STEP
//   cpu_halted      out  state is HALTED
//   cpu_state       out  encoded FSM state
//   cycle_count     out  cycles with core_en high
//   instret_count   out  retired instructions while core_en high
// -----------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int unsigned SRST_CYCLES = 4,
    parameter int unsigned WDT_LIMIT   = 1024
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic [31:0] cpu_ctrl,
    input  logic [31:0] axi_pc_write,
    input  logic        axi_pc_we,
    input  logic        core_halt_req,
    input  logic        core_retire,
    output logic        core_en,
    output logic        core_rst_n,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic [31:0] cpu_status,
    output logic        cpu_running,
    output logic        cpu_halted,
    output logic [2:0]  cpu_state,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    localparam int unsigned SrstW = $clog2(SRST_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StHalted = 3'd3,
        StSrst   = 3'd4
    } state_t;

    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseCtrl = 2'b01;
    localparam logic [1:0] CauseBrk  = 2'b10;
    localparam logic [1:0] CauseWdt  = 2'b11;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_ctrl_prev;
    logic [2:0]         w_ctrl_rise;
    logic [SrstW-1:0]   r_srst_cnt;
    logic               r_core_en;
    logic               r_core_rst_n;
    logic               r_pc_load;
    logic [31:0]        r_pc_load_value;
    logic [31:0]        r_cycle_count;
    logic [31:0]        r_instret_count;
    logic [1:0]         r_cause;
    logic               r_pc_rej;
    logic               w_halt;
    logic [1:0]         w_halt_cause;
    logic               w_idle_or_halted;
    logic               w_running;
    logic               w_halted;
    logic               w_wdt_trip;
    logic               w_wdt_flag;
    logic               w_unused_ctrl;

    // Only run/step/soft-reset need edge detection; bit 3 is a level.
    assign w_ctrl_rise   = cpu_ctrl[2:0] & ~r_ctrl_prev;
    assign w_unused_ctrl = ^cpu_ctrl[31:4];

    assign w_idle_or_halted = (r_state == StIdle) || (r_state == StHalted);
    assign w_running        = (r_state == StRun) || (r_state == StStep);
    assign w_halted         = (r_state == StHalted);

`ifdef CPU_WATCHDOG_EN
    logic [31:0] r_wdt_cnt;
    logic        r_wdt_flag;

    // Fires on the RUN cycle in which the no-retire count reaches WDT_LIMIT.
    assign w_wdt_trip = (r_state == StRun) && !core_retire &&
                        (r_wdt_cnt == WDT_LIMIT - 32'd1);
    assign w_wdt_flag = r_wdt_flag;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wdt_cnt  <= 32'd0;
            r_wdt_flag <= 1'b0;
        end else begin
            if (w_state_nxt == StRun && r_state != StRun) begin
                r_wdt_cnt <= 32'd0;
            end else if (r_state == StRun) begin
                r_wdt_cnt <= core_retire ? 32'd0 : r_wdt_cnt + 32'd1;
            end

            if (w_ctrl_rise[2]) begin
                r_wdt_flag <= 1'b0;
            end else if (w_halt && w_halt_cause == CauseWdt) begin
                r_wdt_flag <= 1'b1;
            end
        end
    end
`else
    logic [31:0] w_unused_wdt_limit;

    assign w_wdt_trip         = 1'b0;
    assign w_wdt_flag         = 1'b0;
    assign w_unused_wdt_limit = WDT_LIMIT;
`endif

    // Next-state decode. Soft-reset edge beats everything; inside each state
    // the halt request beats run-clear, which beats retire/watchdog.
    always_comb begin
        w_state_nxt  = r_state;
        w_halt       = 1'b0;
        w_halt_cause = CauseNone;

        if (w_ctrl_rise[2]) begin
            w_state_nxt = StSrst;
        end else begin
            unique case (r_state)
                StIdle, StHalted: begin
                    if (w_ctrl_rise[0]) begin
                        w_state_nxt = StRun;
                    end else if (w_ctrl_rise[1]) begin
                        w_state_nxt = StStep;
                    end
                end
                StRun: begin
                    if (core_halt_req && cpu_ctrl[3]) begin
                        w_halt       = 1'b1;
                        w_halt_cause = CauseBrk;
                    end else if (!cpu_ctrl[0]) begin
                        w_halt       = 1'b1;
                        w_halt_cause = CauseCtrl;
                    end else if (w_wdt_trip) begin
                        w_halt       = 1'b1;
                        w_halt_cause = CauseWdt;
                    end
                end
                StStep: begin
                    if (core_halt_req) begin
                        w_halt       = 1'b1;
                        w_halt_cause = CauseBrk;
                    end else if (core_retire) begin
                        w_halt       = 1'b1;
                        w_halt_cause = CauseCtrl;
                    end
                end
                StSrst: begin
                    if (r_srst_cnt == SrstW'(1)) begin
                        w_state_nxt = StIdle;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                end
            endcase

            if (w_halt) begin
                w_state_nxt = StHalted;
            end
        end
    end

    // FSM state plus outputs registered from the next state, so core_en and
    // core_rst_n change on the same edge as the state itself.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state      <= StIdle;
            r_ctrl_prev  <= 3'b000;
            r_core_en    <= 1'b0;
            r_core_rst_n <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_ctrl_prev  <= cpu_ctrl[2:0];
            r_core_en    <= (w_state_nxt == StRun) || (w_state_nxt == StStep);
            r_core_rst_n <= (w_state_nxt != StSrst);
        end
    end

    // Soft-reset hold counter: loaded on entry, state leaves SRST when it
    // would decrement from 1 to 0, giving exactly SRST_CYCLES low cycles.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_srst_cnt <= '0;
        end else if (w_ctrl_rise[2]) begin
            r_srst_cnt <= SrstW'(SRST_CYCLES);
        end else if (r_state == StSrst && r_srst_cnt != '0) begin
            r_srst_cnt <= r_srst_cnt - SrstW'(1);
        end
    end

    // Performance counters, halt cause and sticky PC-reject flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_cycle_count   <= 32'd0;
            r_instret_count <= 32'd0;
            r_cause         <= CauseNone;
            r_pc_rej        <= 1'b0;
        end else if (w_ctrl_rise[2]) begin
            r_cycle_count   <= 32'd0;
            r_instret_count <= 32'd0;
            r_cause         <= CauseNone;
            r_pc_rej        <= 1'b0;
        end else begin
            if (r_core_en) begin
                r_cycle_count <= r_cycle_count + 32'd1;
                if (core_retire) begin
                    r_instret_count <= r_instret_count + 32'd1;
                end
            end
            if (w_halt) begin
                r_cause <= w_halt_cause;
            end
            if (axi_pc_we && !w_idle_or_halted) begin
                r_pc_rej <= 1'b1;
            end
        end
    end

    // PC load is only honoured while the core is parked.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_pc_load       <= 1'b0;
            r_pc_load_value <= 32'd0;
        end else begin
            r_pc_load <= axi_pc_we && w_idle_or_halted;
            if (axi_pc_we && w_idle_or_halted) begin
                r_pc_load_value <= axi_pc_write;
            end
        end
    end

    assign core_en       = r_core_en;
    assign core_rst_n    = r_core_rst_n;
    assign pc_load       = r_pc_load;
    assign pc_load_value = r_pc_load_value;
    assign cpu_running   = w_running;
    assign cpu_halted    = w_halted;
    assign cpu_state     = r_state;
    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
    assign cpu_status    = {r_instret_count[15:0], 7'b0000000, r_pc_rej, r_cause,
                            w_wdt_flag, w_halted, w_running, r_state};

endmodule
